// File: rtl/es8psk_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : es8psk_tx_scheduler
// Brief  : Priority/round-robin scheduler feeding the ES 8PSK transmit chain.
// Rev    : 1.0
// ============================================================================
module es8psk_tx_scheduler #(
  parameter int NREQ     = 4,
  parameter int GAP_CYC  = 64,
  parameter int START_TO = 32,
  parameter int MSG_TO   = 4096
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*88-1:0]  req_data_es,
  input  logic [NREQ*204-1:0] req_data_8psk,
  output logic [NREQ-1:0]     req_ack,
  input  logic                tx_ready,
  output logic [87:0]         data_tx,
  output logic [203:0]        data_8psk_tx,
  output logic                ena_data,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic                err_pulse,
  output logic [15:0]         msg_cnt
);

  localparam int c_T1    = (MSG_TO > START_TO) ? MSG_TO : START_TO;
  localparam int c_TMAX  = (c_T1 > GAP_CYC) ? c_T1 : GAP_CYC;
  localparam int c_TMR_W = $clog2(c_TMAX + 1);

  localparam logic [c_TMR_W-1:0] c_START_LAST = c_TMR_W'(START_TO - 1);
  localparam logic [c_TMR_W-1:0] c_MSG_LAST   = c_TMR_W'(MSG_TO - 1);
  localparam logic [c_TMR_W-1:0] c_GAP_LAST   = c_TMR_W'(GAP_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);
  localparam logic [NREQ-1:0]    c_ONE        = NREQ'(1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_LOAD      = 3'd1;
  localparam logic [2:0] c_START     = 3'd2;
  localparam logic [2:0] c_WAIT_LOW  = 3'd3;
  localparam logic [2:0] c_WAIT_HIGH = 3'd4;
  localparam logic [2:0] c_GAP       = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         r_rr;
  logic [2:0]         r_winner;
  logic [c_TMR_W-1:0] r_timer;
  logic [NREQ-1:0]    r_req_ack;
  logic               r_ena_data;
  logic               r_err_pulse;
  logic [15:0]        r_msg_cnt;
  logic [87:0]        r_data_tx;
  logic [203:0]       r_data_8psk_tx;
  logic [2:0]         r_grant_id;

  logic [2:0]         w_winner;
  logic               w_found;
  logic [3:0]         w_idx;
  logic [87:0]        w_sel_es;
  logic [203:0]       w_sel_psk;
  logic               w_still_req;

  // Emergency source wins outright; others scanned from r_rr, wrapping past 0.
  always_comb begin
    w_winner = 3'd0;
    w_found  = 1'b0;
    w_idx    = 4'd0;
    if (req[0]) begin
      w_found = 1'b1;
    end else begin
      for (int i = 0; i < NREQ - 1; i++) begin
        w_idx = {1'b0, r_rr} + 4'(i);
        if (w_idx > 4'(NREQ - 1)) w_idx = w_idx - 4'(NREQ - 1);
        for (int k = 1; k < NREQ; k++) begin
          if (!w_found && (w_idx == 4'(k)) && req[k]) begin
            w_winner = 3'(k);
            w_found  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_sel_es  = req_data_es[87:0];
    w_sel_psk = req_data_8psk[203:0];
    for (int k = 1; k < NREQ; k++) begin
      if (r_winner == 3'(k)) begin
        w_sel_es  = req_data_es[k*88 +: 88];
        w_sel_psk = req_data_8psk[k*204 +: 204];
      end
    end
  end

  assign w_still_req = |(req & (c_ONE << r_winner));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state        <= c_IDLE;
      r_rr           <= 3'd1;
      r_winner       <= 3'd0;
      r_timer        <= '0;
      r_req_ack      <= '0;
      r_ena_data     <= 1'b0;
      r_err_pulse    <= 1'b0;
      r_msg_cnt      <= '0;
      r_data_tx      <= '0;
      r_data_8psk_tx <= '0;
      r_grant_id     <= 3'd0;
    end else begin
      r_req_ack   <= '0;
      r_ena_data  <= 1'b0;
      r_err_pulse <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_winner <= w_winner;
            r_state  <= c_LOAD;
          end
        end
        c_LOAD: begin
          // A request withdrawn before its ack is dropped without side effects.
          if (w_still_req) begin
            r_data_tx      <= w_sel_es;
            r_data_8psk_tx <= w_sel_psk;
            r_grant_id     <= r_winner;
            r_req_ack      <= c_ONE << r_winner;
            if (r_winner != 3'd0)
              r_rr <= (r_winner == 3'(NREQ - 1)) ? 3'd1 : r_winner + 3'd1;
            r_state <= c_START;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_START: begin
          r_ena_data <= 1'b1;
          r_timer    <= '0;
          r_state    <= c_WAIT_LOW;
        end
        c_WAIT_LOW: begin
          if (!tx_ready) begin
            r_timer <= c_TMR_ONE;
            r_state <= c_WAIT_HIGH;
          end else if (r_timer == c_START_LAST) begin
            r_err_pulse <= 1'b1;
            r_timer     <= '0;
            r_state     <= c_GAP;
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end
        c_WAIT_HIGH: begin
          if (tx_ready) begin
            r_msg_cnt <= r_msg_cnt + 16'd1;
            r_timer   <= '0;
            r_state   <= c_GAP;
          end else if (r_timer == c_MSG_LAST) begin
            r_err_pulse <= 1'b1;
            r_timer     <= '0;
            r_state     <= c_GAP;
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end
        c_GAP: begin
          if (r_timer == c_GAP_LAST) r_state <= c_IDLE;
          else                       r_timer <= r_timer + c_TMR_ONE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign req_ack      = r_req_ack;
  assign data_tx      = r_data_tx;
  assign data_8psk_tx = r_data_8psk_tx;
  assign ena_data     = r_ena_data;
  assign busy         = (r_state != c_IDLE);
  assign grant_id     = r_grant_id;
  assign err_pulse    = r_err_pulse;
  assign msg_cnt      = r_msg_cnt;

endmodule
`default_nettype wire
